// File: rtl/scope_pkg.sv
// Shared types for the tile trace-capture block: FSM encoding, source ids, record header.
package scope_pkg;

  localparam int TS_W  = 16;
  localparam int SRC_W = 3;
  localparam int AUX_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Harts use their port index as id; TileLink takes the id just past the last hart.
  localparam logic [SRC_W-1:0] SRC_HART0 = 3'd0;

  typedef struct packed {
    logic [SRC_W-1:0] src_id;
    logic [TS_W-1:0]  ts;
  } rec_hdr_t;

  function automatic logic [SRC_W-1:0] src_id_of(input int idx);
    return SRC_HART0 + SRC_W'(idx);
  endfunction

endpackage

// File: rtl/scope_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the pointer.
// Combinational grant; pointer moves to one past the winner only when adv is asserted.
module scope_rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [N-1:0] req,
  input  logic         adv,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic          found;
  int            win;
  int            idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    win   = 0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
        win        = idx;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (adv && found) begin
      ptr <= PW'((win + 1) % N);
    end
  end

endmodule

// File: rtl/scope_tile_capture.sv
// Passive trace capture of hart retirements and dcache TileLink A-channel beats into a flop FIFO.
// One record per cycle max; rd_data is a registered head with zero latency from rd_valid, drained by rd_ready.
module scope_tile_capture
  import scope_pkg::*;
#(
  parameter int NUM_HARTS = 2,
  parameter int DEPTH     = 16,
  parameter int PC_W      = 32
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic [NUM_HARTS-1:0]           commit_valid,
  input  logic [NUM_HARTS*PC_W-1:0]      commit_pc,
  input  logic [NUM_HARTS*32-1:0]        commit_insn,
  input  logic                           tl_a_valid,
  input  logic                           tl_a_ready,
  input  logic [2:0]                     tl_a_opcode,
  input  logic [PC_W-1:0]                tl_a_address,
  input  logic                           arm,
  input  logic                           mode_wrap,
  input  logic                           trig_en,
  input  logic [PC_W-1:0]                trig_pc,
  input  logic [NUM_HARTS:0]             src_mask,
  output logic                           rd_valid,
  input  logic                           rd_ready,
  output logic [SRC_W+TS_W+PC_W+AUX_W-1:0] rd_data,
  output logic [1:0]                     state,
  output logic [15:0]                    drop_count,
  output logic [$clog2(DEPTH):0]         level
);

  localparam int NSRC = NUM_HARTS + 1;
  localparam int AW   = $clog2(DEPTH);

  typedef struct packed {
    rec_hdr_t         hdr;
    logic [PC_W-1:0]  payload;
    logic [AUX_W-1:0] aux;
  } rec_t;

  state_t          st, st_n;
  logic [TS_W-1:0] ts;
  logic [AW-1:0]   wptr, rptr, wptr_n, rptr_n;
  logic [AW:0]     level_n;
  rec_t            mem [DEPTH];
  rec_t            head_q, head_n, wr_rec;

  logic [NSRC-1:0]      req, grant, sel;
  logic [NUM_HARTS-1:0] hit, trig_sel;
  logic [2:0]           n_req, n_drop;
  logic                 pop, full, wr_en, overwrite, adv;
  logic [16:0]          drop_sum;
  logic [15:0]          drop_n;

  always_comb begin
    req = '0;
    hit = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      req[h] = commit_valid[h] & src_mask[h];
      hit[h] = req[h] && (commit_pc[h*PC_W +: PC_W] == trig_pc);
    end
    req[NUM_HARTS] = tl_a_valid & tl_a_ready & src_mask[NUM_HARTS];
  end

  // Several harts may match the trigger at once; the lowest index is taken as the first record.
  always_comb begin
    trig_sel = '0;
    for (int h = NUM_HARTS - 1; h >= 0; h--) begin
      if (hit[h]) begin
        trig_sel    = '0;
        trig_sel[h] = 1'b1;
      end
    end
  end

  assign n_req    = 3'($countones(req));
  assign rd_valid = (level != '0);
  assign pop      = rd_valid & rd_ready;
  assign full     = (level == (AW+1)'(DEPTH));

  scope_rr_arbiter #(.N(NSRC)) u_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .req     (req),
    .adv     (adv),
    .grant   (grant)
  );

  always_comb begin
    st_n   = st;
    wr_en  = 1'b0;
    adv    = 1'b0;
    sel    = '0;
    n_drop = '0;
    unique case (st)
      ST_IDLE: ;
      ST_ARMED: begin
        if (|hit) begin
          wr_en = 1'b1;
          sel   = {1'b0, trig_sel};
          st_n  = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (|req) begin
          if (!full || mode_wrap || pop) begin
            wr_en  = 1'b1;
            adv    = 1'b1;
            sel    = grant;
            n_drop = n_req - 3'd1;
          end else begin
            n_drop = n_req;
          end
        end
        if (full && !mode_wrap) st_n = ST_DONE;
      end
      ST_DONE: begin
        n_drop = n_req;
        if (level == '0) st_n = ST_IDLE;
      end
    endcase
    if (arm) begin
      st_n   = trig_en ? ST_ARMED : ST_CAPTURE;
      wr_en  = 1'b0;
      adv    = 1'b0;
      n_drop = '0;
    end
  end

  always_comb begin
    wr_rec        = '0;
    wr_rec.hdr.ts = ts;
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (sel[h]) begin
        wr_rec.hdr.src_id = src_id_of(h);
        wr_rec.payload    = commit_pc[h*PC_W +: PC_W];
        wr_rec.aux        = commit_insn[h*32 +: 32];
      end
    end
    if (sel[NUM_HARTS]) begin
      wr_rec.hdr.src_id = src_id_of(NUM_HARTS);
      wr_rec.payload    = tl_a_address;
      wr_rec.aux        = {29'b0, tl_a_opcode};
    end
  end

  // A write into a full wrap buffer without a pop displaces the oldest entry.
  assign overwrite = wr_en & full & ~pop;
  assign wptr_n    = wptr + AW'(wr_en);
  assign rptr_n    = rptr + AW'(pop | overwrite);
  assign level_n   = level + (AW+1)'(wr_en & ~overwrite) - (AW+1)'(pop);

  always_comb begin
    if (level_n == '0)
      head_n = '0;
    else if (wr_en && (wptr == rptr_n))
      head_n = wr_rec;
    else
      head_n = mem[rptr_n];
  end

  assign drop_sum = {1'b0, drop_count} + {14'd0, n_drop};
  assign drop_n   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      st         <= ST_IDLE;
      ts         <= '0;
      wptr       <= '0;
      rptr       <= '0;
      level      <= '0;
      drop_count <= '0;
      head_q     <= '0;
    end else begin
      st <= st_n;
      ts <= ts + 16'd1;
      if (arm) begin
        wptr       <= '0;
        rptr       <= '0;
        level      <= '0;
        drop_count <= '0;
        head_q     <= '0;
      end else begin
        wptr       <= wptr_n;
        rptr       <= rptr_n;
        level      <= level_n;
        drop_count <= drop_n;
        head_q     <= head_n;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wptr] <= wr_rec;
  end

  assign rd_data = head_q;
  assign state   = st;

endmodule
